// File: rtl/ps2_pkg.sv
// Shared types, command constants and frame builder for the PS/2 host link.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    TX,
    ACK,
    WAIT_IDLE,
    FAIL
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  localparam int FRAME_W = 10;
  localparam int IDX_W   = 4;

  // Bit 0 goes out first: data LSB first, then odd parity, then stop.
  function automatic logic [FRAME_W-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 pin plus a falling-edge detector on the
// synchronized level.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Idle bus level is high, so reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte and checks the ACK.
//
// state     | meaning
// IDLE      | lines released, waiting for start
// INHIBIT   | clock held low; data pulled low on the final cycle (start bit)
// REQ       | clock released, waiting for the first device falling edge
// TX        | one frame bit driven per device falling edge
// ACK       | waiting for the ACK edge, data sampled on it
// WAIT_IDLE | waiting for both lines to return high
// FAIL      | timeout or NACK, error pulse
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  ps2_state_t         state;
  logic [CNT_W-1:0]   timer;
  logic [IDX_W-1:0]   idx;
  logic [FRAME_W-1:0] frame;

  logic clk_level;
  logic clk_fall;
  logic dat_level;
  logic dat_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (ps2_dat_in),
    .level (dat_level),
    .fall  (dat_fall_unused)
  );

  // timer is a down-counter; reaching zero is the terminal count of the
  // current phase, and it never decrements past zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      frame      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            frame      <= ps2_frame(data_in);
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            timer      <= CNT_W'(INHIBIT_CYCLES - 1);
            idx        <= '0;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (timer == '0) begin
            ps2_clk_oe <= 1'b0;
            timer      <= CNT_W'(START_TIMEOUT - 1);
            state      <= REQ;
          end else begin
            if (timer == CNT_W'(1)) ps2_dat_oe <= 1'b1;
            timer <= timer - CNT_W'(1);
          end
        end
        REQ: begin
          if (timer == '0) begin
            ps2_dat_oe <= 1'b0;
            state      <= FAIL;
          end else if (clk_fall) begin
            ps2_dat_oe <= ~frame[0];
            idx        <= IDX_W'(1);
            timer      <= CNT_W'(XFER_TIMEOUT - 1);
            state      <= TX;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
        TX: begin
          if (timer == '0) begin
            ps2_dat_oe <= 1'b0;
            state      <= FAIL;
          end else begin
            timer <= timer - CNT_W'(1);
            if (clk_fall) begin
              ps2_dat_oe <= ~frame[idx];
              idx        <= idx + IDX_W'(1);
              if (idx == IDX_W'(FRAME_W - 1)) state <= ACK;
            end
          end
        end
        ACK: begin
          if (timer == '0) begin
            ps2_dat_oe <= 1'b0;
            state      <= FAIL;
          end else begin
            timer <= timer - CNT_W'(1);
            if (clk_fall) state <= dat_level ? FAIL : WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (clk_level && dat_level) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        FAIL: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          error      <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model, PS/2 device clock model and a
// scoreboard of expected frame bits checked at each device rising edge.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 60;
  localparam int ST  = 2000;
  localparam int XT  = 1500;
  localparam int H   = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       busy, done, error;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic busy_at_done = 1'b0, busy_before_done = 1'b0, busy_q = 1'b0;
  logic exp_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (ST),
    .XFER_TIMEOUT   (XT),
    .CNT_W          (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #10 clk = ~clk;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      busy_at_done = busy;
      busy_before_done = busy_q;
    end
    if (error) err_cnt++;
    if (done && error) both_cnt++;
    busy_q = busy;
  end

  task automatic do_start(input logic [7:0] d, input bit push);
    @(negedge clk);
    data_in = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_in = 8'h00;
    if (push) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
      exp_q.push_back(~^d);
      exp_q.push_back(1'b1);
    end
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < INH + 50; i++) begin
      if (ps2_clk_oe === 1'b1 || ps2_dat_oe !== 1'b1) @(negedge clk);
      else begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_wait: clock release with data low not seen, got 0 required 1");
    end
  endtask

  // Device: n falling/rising clock pairs, sampling data at each rising edge.
  task automatic dev_clock(input int n_edges, input bit ack, output int elapsed);
    logic b;
    elapsed = 0;
    repeat (H) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      if (e <= 10) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bit_%0d: got %b, no bit expected", e, ps2_dat_in);
        end else begin
          b = exp_q.pop_front();
          if (ps2_dat_in !== b) begin
            errors++;
            $display("FAIL bit_%0d: got %b required %b", e, ps2_dat_in, b);
          end
        end
      end
      if (e == 11) dev_dat_low = 1'b0;
      repeat (H / 2) @(negedge clk);
      if (e == 10 && ack) dev_dat_low = 1'b1;
      repeat (H - H / 2) @(negedge clk);
      elapsed += 2 * H;
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_pulse(input int d0, input int e0, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0 || err_cnt != e0) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, ps2_clk_oe, ps2_dat_oe} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000",
               {busy, done, error, ps2_clk_oe, ps2_dat_oe});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_led();
    int d0 = done_cnt, e0 = err_cnt, hi = 0, el;
    do_start(CMD_SET_LEDS, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL led_busy: got %b required 1", busy);
    end
    while (ps2_clk_oe === 1'b1 && hi < INH + 50) begin
      hi++;
      @(negedge clk);
    end
    checks++;
    if (hi != INH) begin
      errors++;
      $display("FAIL led_inhibit_len: got %0d cycles required %0d", hi, INH);
    end
    checks++;
    if (ps2_dat_oe !== 1'b1) begin
      errors++;
      $display("FAIL led_start_bit: dat_oe got %b required 1", ps2_dat_oe);
    end
    dev_clock(11, 1'b1, el);
    wait_pulse(d0, e0, 200);
    checks++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      errors++;
      $display("FAIL led_done: done pulses %0d error pulses %0d, required 1 and 0",
               done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (busy_at_done !== 1'b0 || busy_before_done !== 1'b1) begin
      errors++;
      $display("FAIL led_busy_fall: busy at/before done %b%b required 01",
               busy_at_done, busy_before_done);
    end
  endtask

  task automatic test_zero_parity();
    int d0 = done_cnt, e0 = err_cnt, el;
    do_start(8'h00, 1'b1);
    wait_req();
    dev_clock(11, 1'b1, el);
    wait_pulse(d0, e0, 200);
    checks++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      errors++;
      $display("FAIL zero_done: done pulses %0d error pulses %0d, required 1 and 0",
               done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_start_timeout();
    int d0 = done_cnt, n = 0;
    do_start(8'h55, 1'b0);
    wait_req();
    while (error !== 1'b1 && n < ST + 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < ST || n > ST + 4) begin
      errors++;
      $display("FAIL start_timeout: error after %0d cycles required %0d..%0d", n, ST, ST + 4);
    end
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
      errors++;
      $display("FAIL start_timeout_lines: clk_oe/dat_oe/busy %b required 000",
               {ps2_clk_oe, ps2_dat_oe, busy});
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL start_timeout_done: done pulses %0d required 0", done_cnt - d0);
    end
  endtask

  task automatic test_xfer_timeout();
    int d0 = done_cnt, n = 0, el;
    do_start(8'hC3, 1'b1);
    wait_req();
    dev_clock(5, 1'b0, el);
    exp_q.delete();
    while (error !== 1'b1 && n < XT + 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (el + n < XT || el + n > XT + 6) begin
      errors++;
      $display("FAIL xfer_timeout: error %0d cycles after first edge required %0d..%0d",
               el + n, XT, XT + 6);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL xfer_timeout_state: done pulses %0d busy %b required 0 and 0",
               done_cnt - d0, busy);
    end
  endtask

  task automatic test_nack();
    int d0 = done_cnt, e0 = err_cnt, el;
    do_start(CMD_ECHO, 1'b1);
    wait_req();
    dev_clock(11, 1'b0, el);
    wait_pulse(d0, e0, 200);
    checks++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      errors++;
      $display("FAIL nack: error pulses %0d done pulses %0d, required 1 and 0",
               err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_busy_ignore();
    int d0 = done_cnt, e0 = err_cnt, el, hi = 0;
    do_start(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    do_start(8'h3C, 1'b0);
    wait_req();
    dev_clock(11, 1'b1, el);
    wait_pulse(d0, e0, 200);
    checks++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      errors++;
      $display("FAIL busy_ignore_done: done pulses %0d error pulses %0d, required 1 and 0",
               done_cnt - d0, err_cnt - e0);
    end
    for (int i = 0; i < INH + 20; i++) begin
      if (ps2_clk_oe === 1'b1) hi++;
      @(negedge clk);
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL busy_ignore_queued: clk_oe high %0d cycles after done required 0", hi);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt, e0 = err_cnt, el;
    do_start(8'h0F, 1'b1);
    wait_req();
    dev_clock(5, 1'b0, el);
    checks++;
    if (ps2_dat_oe !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_bit4: dat_oe/busy %b%b required 11", ps2_dat_oe, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_release: clk_oe/dat_oe/busy %b required 000",
               {ps2_clk_oe, ps2_dat_oe, busy});
    end
    reset = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      errors++;
      $display("FAIL reset_mid_pulses: done %0d error %0d required 0 and 0",
               done_cnt - d0, err_cnt - e0);
    end
    do_start(CMD_RESET, 1'b1);
    wait_req();
    dev_clock(11, 1'b1, el);
    wait_pulse(d0, e0, 200);
    checks++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      errors++;
      $display("FAIL reset_after_ff: done pulses %0d error pulses %0d, required 1 and 0",
               done_cnt - d0, err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_send_led();
    test_zero_parity();
    test_start_timeout();
    test_xfer_timeout();
    test_nack();
    test_busy_ignore();
    test_reset_mid();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL done_error_overlap: got %0d cycles required 0", both_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_bits: got %0d unsent bits required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
